// File: rtl/cpu_pkg.sv
// Shared constants, FSM state type and address helper for the instruction memory.
package cpu_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int INSTR_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  // True when addr is word aligned and all four bytes fall inside a depth-byte array.
  function automatic logic word_addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr <= (depth - 32'd4));
  endfunction

endpackage

// File: rtl/instr_byte_array.sv
// Byte-wide program storage: one synchronous byte write port, one asynchronous
// little-endian 4-byte read port. Contents are never reset.
module instr_byte_array
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [ADDR_WIDTH-1:0]  wrAddr_i,
  input  logic [7:0]             wrData_i,
  input  logic [ADDR_WIDTH-1:0]  rdAddr_i,
  output logic [INSTR_WIDTH-1:0] rdWord_o
);

  localparam int IW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0]            mem_q [DEPTH_BYTES];
  logic [ADDR_WIDTH-1:0] byteAddr;

  // Byte write from the program-load port; range filtering is done by the caller.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wrAddr_i[IW-1:0]] <= wrData_i;
    end
  end

  // Assemble the word little-endian: byte at rdAddr_i lands in bits [7:0].
  always_comb begin
    rdWord_o = '0;
    byteAddr = '0;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      byteAddr = rdAddr_i + ADDR_WIDTH'(k);
      rdWord_o[8*k +: 8] = mem_q[byteAddr[IW-1:0]];
    end
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: multi-cycle fetch with BUSYWAIT stall,
// one-entry fetch buffer for zero-stall refetch, and a byte program-load port.
module instr_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DEPTH_BYTES  = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   READ,
  input  logic [ADDR_WIDTH-1:0]  ADDRESS,
  output logic [INSTR_WIDTH-1:0] INSTRUCTION,
  output logic                   BUSYWAIT,
  output logic                   ERROR,
  input  logic                   LOAD_EN,
  input  logic [ADDR_WIDTH-1:0]  LOAD_ADDR,
  input  logic [7:0]             LOAD_DATA
);

  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] RELOAD = CW'(READ_LATENCY - 1);

  fetch_state_e           state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [ADDR_WIDTH-1:0]  reqAddr_q, reqAddr_d;
  logic [ADDR_WIDTH-1:0]  bufAddr_q, bufAddr_d;
  logic                   bufValid_q, bufValid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;

  logic                   loadOk;
  logic                   bad;
  logic                   hit;
  logic                   busy;
  logic                   err;
  logic [INSTR_WIDTH-1:0] rdWord;

  assign loadOk = LOAD_EN && ({1'b0, LOAD_ADDR} < (ADDR_WIDTH + 1)'(DEPTH_BYTES));
  assign bad    = !word_addr_ok(32'(ADDRESS), DEPTH_BYTES);
  assign hit    = bufValid_q && (bufAddr_q == ADDRESS);

  instr_byte_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (loadOk),
    .wrAddr_i(LOAD_ADDR),
    .wrData_i(LOAD_DATA),
    .rdAddr_i(reqAddr_q),
    .rdWord_o(rdWord)
  );

  // Next-state logic: start fetches on misses, count down latency, capture the word.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reqAddr_d  = reqAddr_q;
    bufAddr_d  = bufAddr_q;
    bufValid_d = bufValid_q;
    instr_d    = instr_q;
    busy       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (READ) begin
          if (bad) begin
            err = 1'b1;
          end else if (!hit) begin
            busy      = 1'b1;
            reqAddr_d = ADDRESS;
            count_d   = RELOAD;
            state_d   = FETCH;
          end
        end
      end
      FETCH: begin
        busy = 1'b1;
        if (loadOk) begin
          count_d = RELOAD;
        end else if (count_q != '0) begin
          count_d = count_q - CW'(1);
        end else begin
          instr_d    = rdWord;
          bufAddr_d  = reqAddr_q;
          bufValid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (loadOk) begin
      bufValid_d = 1'b0;
    end
  end

  // State, counter and fetch-buffer registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reqAddr_q  <= '0;
      bufAddr_q  <= '0;
      bufValid_q <= 1'b0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reqAddr_q  <= reqAddr_d;
      bufAddr_q  <= bufAddr_d;
      bufValid_q <= bufValid_d;
      instr_q    <= instr_d;
    end
  end

  assign INSTRUCTION = instr_q;
  assign BUSYWAIT    = RESET && busy;
  assign ERROR       = RESET && err;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
`timescale 1ns/100ps
module tb_instr_mem_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 512;
  localparam int RL    = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          READ;
  logic [AW-1:0] ADDRESS;
  logic [31:0]   INSTRUCTION;
  logic          BUSYWAIT;
  logic          ERROR;
  logic          LOAD_EN;
  logic [AW-1:0] LOAD_ADDR;
  logic [7:0]    LOAD_DATA;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: byte image, pending fetch and one-entry buffer.
  logic [7:0]    mMem [DEPTH];
  logic          mBusy;
  int            mRemain;
  logic [AW-1:0] mReqAddr;
  logic          mBufValid;
  logic [AW-1:0] mBufAddr;
  logic [31:0]   mInstr;

  instr_mem_ctrl #(
    .ADDR_WIDTH  (AW),
    .DEPTH_BYTES (DEPTH),
    .READ_LATENCY(RL)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .READ       (READ),
    .ADDRESS    (ADDRESS),
    .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT   (BUSYWAIT),
    .ERROR      (ERROR),
    .LOAD_EN    (LOAD_EN),
    .LOAD_ADDR  (LOAD_ADDR),
    .LOAD_DATA  (LOAD_DATA)
  );

  // Free-running 100 MHz clock.
  always #5 CLK = ~CLK;

  // Hard time limit so the run can never hang.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic isBad(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || (int'(a) > DEPTH - 4);
  endfunction

  function automatic logic [31:0] wordAt(input logic [AW-1:0] a);
    int b;
    b = int'(a);
    return {mMem[b+3], mMem[b+2], mMem[b+1], mMem[b]};
  endfunction

  task automatic modelReset();
    mBusy     = 1'b0;
    mRemain   = 0;
    mReqAddr  = '0;
    mBufValid = 1'b0;
    mBufAddr  = '0;
    mInstr    = '0;
  endtask

  // Advance the model across one rising edge using the inputs driven before it.
  task automatic modelEdge();
    logic loadOk;
    loadOk = LOAD_EN && (int'(LOAD_ADDR) < DEPTH);
    if (RESET) begin
      if (mBusy) begin
        if (loadOk) begin
          mRemain = RL;
        end else begin
          mRemain--;
          if (mRemain == 0) begin
            mInstr    = wordAt(mReqAddr);
            mBufAddr  = mReqAddr;
            mBufValid = 1'b1;
            mBusy     = 1'b0;
          end
        end
      end else if (READ && !isBad(ADDRESS) && !(mBufValid && mBufAddr == ADDRESS)) begin
        mBusy    = 1'b1;
        mRemain  = RL;
        mReqAddr = ADDRESS;
      end
      if (loadOk) mBufValid = 1'b0;
    end
    if (loadOk) mMem[int'(LOAD_ADDR)] = LOAD_DATA;
  endtask

  task automatic checkAll(input string tag);
    logic bad, hit, eb, ee;
    bad = isBad(ADDRESS);
    hit = mBufValid && (mBufAddr == ADDRESS);
    eb  = RESET && (mBusy || (READ && !bad && !hit));
    ee  = RESET && !mBusy && READ && bad;
    checkOutput({tag, "/busy"},  {31'b0, BUSYWAIT}, {31'b0, eb});
    checkOutput({tag, "/error"}, {31'b0, ERROR},    {31'b0, ee});
    checkOutput({tag, "/instr"}, INSTRUCTION,       mInstr);
  endtask

  task automatic applyStimulus(input logic rd, input logic [AW-1:0] addr,
                               input logic ld, input logic [AW-1:0] la, input logic [7:0] dat);
    READ      = rd;
    ADDRESS   = addr;
    LOAD_EN   = ld;
    LOAD_ADDR = la;
    LOAD_DATA = dat;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input string tag);
    @(negedge CLK);
    checkAll(tag);
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  task automatic cycleExpect(input string tag, input logic eb, input logic ee, input logic [31:0] ew);
    @(negedge CLK);
    checkAll(tag);
    checkOutput({tag, "_busy"},  {31'b0, BUSYWAIT}, {31'b0, eb});
    checkOutput({tag, "_error"}, {31'b0, ERROR},    {31'b0, ee});
    checkOutput({tag, "_word"},  INSTRUCTION,       ew);
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  // Count stalled cycles until BUSYWAIT drops; returns the word seen on that cycle.
  task automatic countStall(input string tag, output int n, output logic [31:0] word);
    logic busyNow;
    n    = 0;
    word = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      checkAll(tag);
      busyNow = BUSYWAIT;
      word    = INSTRUCTION;
      @(posedge CLK);
      modelEdge();
      #1;
      LOAD_EN = 1'b0;
      if (!busyNow) break;
      n++;
    end
  endtask

  task automatic runFetch(input string tag, input logic [AW-1:0] addr, input logic [31:0] expWord);
    int          n;
    logic [31:0] w;
    applyStimulus(1'b1, addr, 1'b0, '0, '0);
    countStall(tag, n, w);
    checkOutput({tag, "_stall"}, n, RL + 1);
    checkOutput({tag, "_word"},  w, expWord);
  endtask

  function automatic logic [AW-1:0] pickAddr();
    case ($urandom_range(0, 9))
      0: return AW'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      1: case ($urandom_range(0, 2))
           0: return AW'(DEPTH - 4);
           1: return AW'(DEPTH);
           default: return AW'(1020);
         endcase
      2: return AW'($urandom);
      default: return AW'($urandom_range(0, 15) * 4);
    endcase
  endfunction

  initial begin
    int          n;
    logic [31:0] w;
    logic [31:0] w8;
    logic [31:0] expLd;

    RESET = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    modelReset();
    for (int i = 0; i < DEPTH; i++) mMem[i] = '0;

    // Preload every byte while held in reset, then place the first instruction.
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, '0, 1'b1, AW'(a), 8'($urandom));
      cycle("preload");
    end
    applyStimulus(1'b0, '0, 1'b1, AW'(0), 8'h0A); cycle("ld0");
    applyStimulus(1'b0, '0, 1'b1, AW'(1), 8'h00); cycle("ld1");
    applyStimulus(1'b0, '0, 1'b1, AW'(2), 8'h06); cycle("ld2");
    applyStimulus(1'b0, '0, 1'b1, AW'(3), 8'h08); cycle("ld3");
    applyStimulus(1'b1, '0, 1'b0, '0, '0);
    cycleExpect("reset", 1'b0, 1'b0, 32'h0);

    RESET = 1'b1;
    runFetch("first", AW'(0), 32'h0806000A);
    for (int i = 0; i < 4; i++) cycleExpect("hit", 1'b0, 1'b0, 32'h0806000A);

    applyStimulus(1'b0, '0, 1'b1, AW'(16), 8'h03); cycle("ld16");
    applyStimulus(1'b0, '0, 1'b1, AW'(17), 8'h06); cycle("ld17");
    applyStimulus(1'b0, '0, 1'b1, AW'(18), 8'h02); cycle("ld18");
    applyStimulus(1'b0, '0, 1'b1, AW'(19), 8'h19); cycle("ld19");
    runFetch("step16", AW'(16), 32'h19020603);

    applyStimulus(1'b1, AW'(2), 1'b0, '0, '0);
    cycleExpect("misalign", 1'b0, 1'b1, 32'h19020603);
    applyStimulus(1'b1, AW'(1022), 1'b0, '0, '0);
    cycleExpect("addr1022", 1'b0, 1'b1, 32'h19020603);
    applyStimulus(1'b1, AW'(DEPTH), 1'b0, '0, '0);
    cycleExpect("pastEnd", 1'b0, 1'b1, 32'h19020603);
    runFetch("lastWord", AW'(DEPTH - 4), wordAt(AW'(DEPTH - 4)));

    // Load lands on the fetched word while the fetch is in flight.
    applyStimulus(1'b1, AW'(4), 1'b0, '0, '0);
    cycle("ldReq");
    applyStimulus(1'b1, AW'(4), 1'b1, AW'(4), 8'hAA);
    countStall("ldFetch", n, w);
    expLd = {mMem[7], mMem[6], mMem[5], 8'hAA};
    checkOutput("ldFetch_stall", n, RL + 1);
    checkOutput("ldFetch_low", {24'b0, w[7:0]}, 32'h000000AA);
    checkOutput("ldFetch_word", w, expLd);

    // Short reset pulse between edges aborts a fetch in flight.
    w8 = wordAt(AW'(8));
    applyStimulus(1'b1, AW'(8), 1'b0, '0, '0);
    cycle("rstReq");
    #1;
    RESET = 1'b0;
    modelReset();
    #0.5;
    checkOutput("rstPulse_busy",  {31'b0, BUSYWAIT}, 32'h0);
    checkOutput("rstPulse_instr", INSTRUCTION, 32'h0);
    checkOutput("rstPulse_error", {31'b0, ERROR}, 32'h0);
    #0.5;
    RESET = 1'b1;
    runFetch("afterRst", AW'(8), w8);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      RESET = ($urandom_range(0, 63) != 0);
      if (!RESET) modelReset();
      applyStimulus($urandom_range(0, 3) != 0, pickAddr(),
                    $urandom_range(0, 9) == 0,
                    ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63)),
                    8'($urandom));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
